// File: rtl/binary_frame_buffer_pkg.sv
// rtl/binary_frame_buffer_pkg.sv - Shared frame geometry and frame-buffer state encoding
package binary_frame_buffer_pkg;

   localparam int WIDTH_BITS  = 8;
   localparam int HEIGHT_BITS = 8;
   localparam int PACK_BITS   = 3;
   localparam int WORDS       = 1 << (WIDTH_BITS + HEIGHT_BITS - PACK_BITS);
   localparam int PIXELS      = 1 << (WIDTH_BITS + HEIGHT_BITS);

   typedef enum logic [1:0] {
      CLEAR   = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } bfb_state_e;

endpackage

// File: rtl/binary_frame_buffer_if.sv
// rtl/binary_frame_buffer_if.sv - Pixel write, readout and status bundle of the frame buffer
interface binary_frame_buffer_if
   import binary_frame_buffer_pkg::*;
#(
   parameter int WB = WIDTH_BITS,
   parameter int HB = HEIGHT_BITS
);
   logic          iWren;
   logic [WB-1:0] iX;
   logic [HB-1:0] iY;
   logic          iValue;
   logic          oReady;
   logic          iClear;
   logic          iReadEn;
   logic [WB-1:0] iReadX;
   logic [HB-1:0] iReadY;
   logic          oReadValid;
   logic          oReadValue;
   logic [WB+HB:0] oPixelCount;
   logic          oDone;
   logic          oOverflow;

   modport slave (
      input  iWren, iX, iY, iValue, iClear, iReadEn, iReadX, iReadY,
      output oReady, oReadValid, oReadValue, oPixelCount, oDone, oOverflow
   );

   modport master (
      output iWren, iX, iY, iValue, iClear, iReadEn, iReadX, iReadY,
      input  oReady, oReadValid, oReadValue, oPixelCount, oDone, oOverflow
   );
endinterface

// File: rtl/bfb_ram.sv
// rtl/bfb_ram.sv - Simple dual-port synchronous RAM, one-cycle read, old data on collision
module bfb_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 13
) (
   input  logic              clock,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);
   logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];

   always_ff @(posedge clock) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      o_rd_data <= r_mem[i_rd_addr];
   end
endmodule

// File: rtl/binary_frame_buffer.sv
// rtl/binary_frame_buffer.sv - Bit-packed binary frame store: clear sweep, RMW capture, pipelined readout
module binary_frame_buffer
   import binary_frame_buffer_pkg::*;
#(
   parameter int W_BITS = WIDTH_BITS,
   parameter int H_BITS = HEIGHT_BITS,
   parameter int P_BITS = PACK_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   binary_frame_buffer_if.slave bus
);
   localparam int AW = W_BITS + H_BITS - P_BITS;
   localparam int DW = 1 << P_BITS;
   localparam int CW = W_BITS + H_BITS + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(1) << (W_BITS + H_BITS);

   bfb_state_e        r_state, w_next_state;
   logic [AW-1:0]     r_clr_addr;
   logic              r_p1_valid, r_p1_value;
   logic [AW-1:0]     r_p1_addr;
   logic [P_BITS-1:0] r_p1_bit;
   logic              r_fwd_valid;
   logic [AW-1:0]     r_fwd_addr;
   logic [DW-1:0]     r_fwd_data;
   logic [CW-1:0]     r_count;
   logic              r_overflow;
   logic              r_rd_s1_valid, r_read_valid, r_read_value;
   logic [P_BITS-1:0] r_rd_s1_bit;
   logic              w_accept, w_rd_req, w_commit, w_we;
   logic [AW-1:0]     w_raddr, w_waddr;
   logic [DW-1:0]     w_ram_rdata, w_base, w_merged, w_wdata;

   assign w_accept = (r_state == CAPTURE) && bus.iWren && !bus.iClear;
   assign w_rd_req = (r_state == DONE) && bus.iReadEn && !bus.iClear;
   assign w_commit = r_p1_valid && !bus.iClear;

   // The read port belongs to the readout only in DONE, where no capture is possible.
   assign w_raddr = (r_state == DONE) ? {bus.iReadY, bus.iReadX[W_BITS-1:P_BITS]}
                                      : {bus.iY, bus.iX[W_BITS-1:P_BITS]};
   // The RAM still holds the old word when the previous pixel hit the same address.
   assign w_base  = (r_fwd_valid && (r_fwd_addr == r_p1_addr)) ? r_fwd_data : w_ram_rdata;

   always_comb begin
      w_merged = w_base;
      w_merged[r_p1_bit] = r_p1_value;
   end

   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_clr_addr;
      w_wdata = '0;
      if (r_state == CLEAR) begin
         w_we = 1'b1;
      end else if (w_commit) begin
         w_we    = 1'b1;
         w_waddr = r_p1_addr;
         w_wdata = w_merged;
      end
   end

   bfb_ram #(.DATA_W(DW), .ADDR_W(AW)) u_ram (
      .clock     (clock),
      .i_wr_en   (w_we),
      .i_wr_addr (w_waddr),
      .i_wr_data (w_wdata),
      .i_rd_addr (w_raddr),
      .o_rd_data (w_ram_rdata)
   );

   always_comb begin
      w_next_state = r_state;
      if (bus.iClear) begin
         w_next_state = CLEAR;
      end else begin
         case (r_state)
            CLEAR:   if (&r_clr_addr) w_next_state = CAPTURE;
            CAPTURE: if (r_count == FULL_COUNT) w_next_state = DONE;
            DONE:    w_next_state = DONE;
            default: w_next_state = CLEAR;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= CLEAR;
      else       r_state <= w_next_state;
   end

   always_ff @(posedge clock) begin
      if (reset || bus.iClear || (r_state != CLEAR)) r_clr_addr <= '0;
      else                                           r_clr_addr <= r_clr_addr + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset || bus.iClear) begin
         r_p1_valid    <= 1'b0;
         r_fwd_valid   <= 1'b0;
         r_count       <= '0;
         r_overflow    <= 1'b0;
         r_rd_s1_valid <= 1'b0;
         r_read_valid  <= 1'b0;
         r_read_value  <= 1'b0;
      end else begin
         r_p1_valid    <= w_accept;
         if (w_commit) r_fwd_valid <= 1'b1;
         if (w_accept) r_count <= r_count + 1'b1;
         if ((r_state == DONE) && bus.iWren) r_overflow <= 1'b1;
         r_rd_s1_valid <= w_rd_req;
         r_read_valid  <= r_rd_s1_valid;
         r_read_value  <= r_rd_s1_valid & w_ram_rdata[r_rd_s1_bit];
      end
   end

   always_ff @(posedge clock) begin
      if (w_accept) begin
         r_p1_addr  <= {bus.iY, bus.iX[W_BITS-1:P_BITS]};
         r_p1_bit   <= bus.iX[P_BITS-1:0];
         r_p1_value <= bus.iValue;
      end
      if (w_commit) begin
         r_fwd_addr <= r_p1_addr;
         r_fwd_data <= w_merged;
      end
      r_rd_s1_bit <= bus.iReadX[P_BITS-1:0];
   end

   assign bus.oReady      = (r_state == CAPTURE);
   assign bus.oDone       = (r_state == DONE);
   assign bus.oPixelCount = r_count;
   assign bus.oOverflow   = r_overflow;
   assign bus.oReadValid  = r_read_valid;
   assign bus.oReadValue  = r_read_value;
endmodule

// File: tb/tb_binary_frame_buffer.sv
// tb/tb_binary_frame_buffer.sv - Scoreboard bench for binary_frame_buffer on a 16x16 frame
module tb_binary_frame_buffer;
   logic clock;
   logic reset;
   int   checks;
   int   failures;

   binary_frame_buffer_if #(.WB(4), .HB(4)) bus();

   binary_frame_buffer #(.W_BITS(4), .H_BITS(4), .P_BITS(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int   x;
      int   y;
      logic v;
   } rd_exp_t;

   rd_exp_t exp_q[$];
   rd_exp_t mon_e;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
      end
   endtask

   // Scoreboard monitor: every readout beat must match the oldest expected read.
   always @(negedge clock) begin
      if (bus.oReadValid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL read_unexpected actual=valid expected=no read outstanding");
         end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("read(%0d,%0d)", mon_e.x, mon_e.y), int'(bus.oReadValue), int'(mon_e.v));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.iWren   = 1'b0;
      bus.iX      = '0;
      bus.iY      = '0;
      bus.iValue  = 1'b0;
      bus.iClear  = 1'b0;
      bus.iReadEn = 1'b0;
      bus.iReadX  = '0;
      bus.iReadY  = '0;
   endtask

   task automatic wr(input int x, input int y, input logic v);
      bus.iWren  = 1'b1;
      bus.iX     = x[3:0];
      bus.iY     = y[3:0];
      bus.iValue = v;
      tick();
   endtask

   task automatic rd(input int x, input int y, input logic v);
      rd_exp_t e;
      e.x = x;
      e.y = y;
      e.v = v;
      exp_q.push_back(e);
      bus.iReadEn = 1'b1;
      bus.iReadX  = x[3:0];
      bus.iReadY  = y[3:0];
      tick();
   endtask

   task automatic drain(input string tag);
      bus.iReadEn = 1'b0;
      repeat (4) tick();
      check({tag, "_drain"}, exp_q.size(), 0);
   endtask

   // Entered in the first sweep cycle; the sweep lasts 32 cycles.
   task automatic wait_clear(input string tag);
      repeat (31) tick();
      check({tag, "_ready_lo"}, int'(bus.oReady), 0);
      tick();
      check({tag, "_ready_hi"}, int'(bus.oReady), 1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      idle();
      reset = 1'b1;
      tick();
      check("rst_ready", int'(bus.oReady), 0);
      check("rst_done", int'(bus.oDone), 0);
      check("rst_count", int'(bus.oPixelCount), 0);
      check("rst_ovf", int'(bus.oOverflow), 0);
      check("rst_rvalid", int'(bus.oReadValid), 0);
      check("rst_rvalue", int'(bus.oReadValue), 0);
      tick();
      reset = 1'b0;
      wait_clear("pwr");

      // Frame A: same-word burst at full rate, then (x^y)&1 raster for the rest.
      for (int x = 0; x < 8; x++) begin
         wr(x, 9, 1'b1);
         if (x == 0) check("cnt_first", int'(bus.oPixelCount), 1);
      end
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            if (!(y == 9 && x < 8)) wr(x, y, 1'(x ^ y));
      bus.iWren = 1'b0;
      check("a_count", int'(bus.oPixelCount), 256);
      check("a_done_early", int'(bus.oDone), 0);
      tick();
      check("a_done", int'(bus.oDone), 1);
      check("a_ready", int'(bus.oReady), 0);

      rd(3, 4, 1'b1);
      bus.iReadEn = 1'b0;
      check("rd_lat_t1", int'(bus.oReadValid), 0);
      tick();
      check("rd_lat_t2", int'(bus.oReadValid), 1);
      drain("a_single");

      rd(3, 5, 1'b0);
      for (int x = 0; x < 8; x++) rd(x, 9, 1'b1);
      rd(8, 9, 1'b1);
      rd(15, 14, 1'b1);
      rd(0, 0, 1'b0);
      drain("a_burst");

      wr(0, 0, 1'b1);
      bus.iWren = 1'b0;
      check("ovf_set", int'(bus.oOverflow), 1);
      repeat (3) tick();
      check("ovf_sticky", int'(bus.oOverflow), 1);
      check("ovf_count", int'(bus.oPixelCount), 256);
      check("ovf_done", int'(bus.oDone), 1);

      bus.iClear = 1'b1;
      tick();
      bus.iClear = 1'b0;
      check("clr_ovf", int'(bus.oOverflow), 0);
      check("clr_done", int'(bus.oDone), 0);
      check("clr_count", int'(bus.oPixelCount), 0);
      check("clr_ready", int'(bus.oReady), 0);
      bus.iReadEn = 1'b1;
      bus.iReadX  = 4'd3;
      bus.iReadY  = 4'd4;
      tick();
      bus.iReadEn = 1'b0;
      tick();
      check("clr_read_ignored", int'(bus.oReadValid), 0);
      repeat (29) tick();
      check("clr_ready_lo", int'(bus.oReady), 0);
      tick();
      check("clr_ready_hi", int'(bus.oReady), 1);

      // Frame B: duplicate pixel, last value wins; (15,15) never written.
      wr(10, 10, 1'b1);
      wr(10, 10, 1'b0);
      check("b_dup_count", int'(bus.oPixelCount), 2);
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            if (!(x == 10 && y == 10) && !(x == 15 && y == 15)) wr(x, y, 1'b1);
      bus.iWren = 1'b0;
      check("b_count", int'(bus.oPixelCount), 256);
      tick();
      check("b_done", int'(bus.oDone), 1);
      rd(10, 10, 1'b0);
      rd(15, 15, 1'b0);
      rd(11, 10, 1'b1);
      rd(9, 10, 1'b1);
      rd(10, 9, 1'b1);
      drain("b");

      bus.iClear = 1'b1;
      tick();
      bus.iClear = 1'b0;
      wait_clear("clr2");

      // Frame C: reset in the middle of capture forces a full re-clear.
      for (int i = 0; i < 100; i++) wr(i % 16, i / 16, 1'b1);
      bus.iWren = 1'b0;
      check("c_partial_count", int'(bus.oPixelCount), 100);
      reset = 1'b1;
      tick();
      check("c_rst_count", int'(bus.oPixelCount), 0);
      check("c_rst_ready", int'(bus.oReady), 0);
      check("c_rst_done", int'(bus.oDone), 0);
      reset = 1'b0;
      wait_clear("rst2");
      for (int i = 0; i < 256; i++) wr(5, 5, 1'b1);
      bus.iWren = 1'b0;
      check("c_count", int'(bus.oPixelCount), 256);
      tick();
      check("c_done", int'(bus.oDone), 1);
      rd(5, 5, 1'b1);
      rd(4, 5, 1'b0);
      rd(0, 0, 1'b0);
      rd(7, 5, 1'b0);
      rd(5, 4, 1'b0);
      drain("c");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
